udp_tx_arbiter: RTL

Shares the single UDP transmit port of the Ethernet MAC between NUM_REQ stream sources: rxstream IQ, wideband stream and the discovery/control reply. Each source presents the same request/enable/data/length interface it would give the MAC directly. The arbiter picks one source round-robin, forwards its request and length to the MAC, routes the MAC enable pulse back to the winner, and muxes the winner's bytes for the duration of the packet.

---
 rtl/udp_tx_arbiter_pkg.sv | 21 ++
 rtl/udp_tx_arbiter_rr_pick.sv | 32 +++
 rtl/udp_tx_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and widths for the UDP transmit arbiter.
// Holds the FSM state encoding and the MAC-facing field widths.
package udp_tx_arbiter_pkg;

   localparam int UDP_LEN_W  = 11;
   localparam int UDP_DATA_W = 8;
   localparam int TCOUNT_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Width of an index into n sources; never zero so a single source still gets a bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
// Output grant is one-hot or all zero.
module rr_pick
   import udp_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               any_valid
);

   always_comb begin
      logic [PTR_W-1:0] idx;
      logic             found;
      grant = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
         idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin sharing of the MAC UDP transmit port between NUM_REQ stream sources.
// Handshake: a source holds src_request with a nonzero length; the MAC answers udp_tx_request with one udp_tx_enable pulse, forwarded as src_enable.
module udp_tx_arbiter
   import udp_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int TIMEOUT    = 4096,
   parameter int IFG_CYCLES = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            have_ip,
   input  logic [NUM_REQ-1:0]              src_request,
   input  logic [UDP_LEN_W*NUM_REQ-1:0]    src_length,
   input  logic [UDP_DATA_W*NUM_REQ-1:0]   src_data,
   output logic [NUM_REQ-1:0]              src_enable,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            udp_tx_request,
   input  logic                            udp_tx_enable,
   output logic [UDP_LEN_W-1:0]            udp_tx_length,
   output logic [UDP_DATA_W-1:0]           udp_tx_data,
   output logic                            busy,
   output logic [TCOUNT_W-1:0]             timeout_count
);

   localparam int PTR_W  = ptr_width(NUM_REQ);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

   state_t                 state_q, state_n;
   logic [NUM_REQ-1:0]     grant_q, grant_n;
   logic                   req_q, req_n;
   logic [UDP_LEN_W-1:0]   len_q, len_n;
   logic [UDP_LEN_W-1:0]   byte_q, byte_n;
   logic [WAIT_W-1:0]      wait_q, wait_n;
   logic [GAP_W-1:0]       gap_q, gap_n;
   logic [PTR_W-1:0]       ptr_q, ptr_n;
   logic [TCOUNT_W-1:0]    tcount_q, tcount_n;

   logic [NUM_REQ-1:0]     valid;
   logic [NUM_REQ-1:0]     pick;
   logic                   any_valid;
   logic [UDP_LEN_W-1:0]   pick_len;
   logic [PTR_W-1:0]       win_idx;
   logic [PTR_W-1:0]       ptr_after_win;

   // Zero-length requests are not eligible.
   always_comb begin
      valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid[i] = src_request[i] && (src_length[i*UDP_LEN_W +: UDP_LEN_W] != '0);
      end
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .valid     (valid),
      .ptr       (ptr_q),
      .grant     (pick),
      .any_valid (any_valid)
   );

   always_comb begin
      pick_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_len = pick_len | src_length[i*UDP_LEN_W +: UDP_LEN_W];
      end
   end

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) win_idx = PTR_W'(i);
      end
      ptr_after_win = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      udp_tx_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) udp_tx_data = udp_tx_data | src_data[i*UDP_DATA_W +: UDP_DATA_W];
      end
   end

   always_comb begin
      state_n  = state_q;
      grant_n  = grant_q;
      req_n    = req_q;
      len_n    = len_q;
      byte_n   = byte_q;
      wait_n   = wait_q;
      gap_n    = gap_q;
      ptr_n    = ptr_q;
      tcount_n = tcount_q;
      case (state_q)
         ST_IDLE: begin
            if (have_ip && any_valid) begin
               state_n = ST_REQ;
               grant_n = pick;
               len_n   = pick_len;
               req_n   = 1'b1;
               wait_n  = '0;
            end
         end
         ST_REQ: begin
            wait_n = wait_q + 1'b1;
            // Enable beats both withdrawal and timeout in the same cycle.
            if (udp_tx_enable) begin
               state_n = ST_SEND;
               req_n   = 1'b0;
               byte_n  = len_q;
            end else if ((src_request & grant_q) == '0) begin
               state_n = ST_IDLE;
               req_n   = 1'b0;
               grant_n = '0;
            end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
               state_n = ST_GAP;
               req_n   = 1'b0;
               grant_n = '0;
               ptr_n   = ptr_after_win;
               gap_n   = GAP_W'(IFG_CYCLES);
               if (tcount_q != '1) tcount_n = tcount_q + 1'b1;
            end
         end
         ST_SEND: begin
            if (byte_q <= UDP_LEN_W'(1)) begin
               state_n = ST_GAP;
               grant_n = '0;
               ptr_n   = ptr_after_win;
               gap_n   = GAP_W'(IFG_CYCLES);
            end else begin
               byte_n = byte_q - 1'b1;
            end
         end
         ST_GAP: begin
            // A zero-length gap still spends one cycle here.
            if (gap_q <= GAP_W'(1)) state_n = ST_IDLE;
            else                    gap_n   = gap_q - 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         req_q    <= 1'b0;
         len_q    <= '0;
         byte_q   <= '0;
         wait_q   <= '0;
         gap_q    <= '0;
         ptr_q    <= '0;
         tcount_q <= '0;
      end else begin
         state_q  <= state_n;
         grant_q  <= grant_n;
         req_q    <= req_n;
         len_q    <= len_n;
         byte_q   <= byte_n;
         wait_q   <= wait_n;
         gap_q    <= gap_n;
         ptr_q    <= ptr_n;
         tcount_q <= tcount_n;
      end
   end

   assign src_enable     = (state_q == ST_REQ && udp_tx_enable) ? grant_q : '0;
   assign grant          = grant_q;
   assign udp_tx_request = req_q;
   assign udp_tx_length  = len_q;
   assign busy           = (state_q != ST_IDLE);
   assign timeout_count  = tcount_q;

endmodule
